// File: rtl/client_limit_arbiter.sv
// Round-robin arbiter serialising CPU limit updates and exchange orders onto a shared per-client risk table.
// Orders are accepted only while the client's running total stays within its configured maximum.
module client_limit_arbiter #(
  parameter int NCLIENT = 32,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_go,
  input  logic          cpu_new_max,
  input  logic [4:0]    cpu_client_id,
  input  logic [AW-1:0] cpu_amount,
  input  logic          exchange_go,
  input  logic [4:0]    exchange_client_id,
  input  logic [AW-1:0] exchange_amount,
  output logic [AW-1:0] accumulated_orders,
  output logic [AW-1:0] cancelled_orders,
  output logic          order_done,
  output logic          order_accept,
  output logic          busy,
  output logic          cpu_drop,
  output logic          exch_drop
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] max_tab [NCLIENT];
  logic [AW-1:0] acc_tab [NCLIENT];

  logic          cpu_vld, cpu_nm;
  logic [4:0]    cpu_id;
  logic [AW-1:0] cpu_amt;
  logic          ex_vld;
  logic [4:0]    ex_id;
  logic [AW-1:0] ex_amt;

  logic          last_cpu;   // 1 = CPU won the most recent tie
  logic          op_cpu, op_nm;
  logic [4:0]    op_id;
  logic [AW-1:0] op_amt;
  logic [AW-1:0] rd_max, rd_acc;

  logic          grant_cpu, grant_ex;
  logic [AW:0]   sum;
  logic          fits;

  assign grant_cpu = (state == IDLE) && cpu_vld && (!ex_vld || !last_cpu);
  assign grant_ex  = (state == IDLE) && ex_vld && !grant_cpu;
  assign sum       = {1'b0, rd_acc} + {1'b0, op_amt};
  assign fits      = !sum[AW] && (sum[AW-1:0] <= rd_max);
  assign busy      = (state != IDLE) || cpu_vld || ex_vld;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_vld || ex_vld) state_nxt = RD;
      RD:      state_nxt = WR;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pending slots and arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_vld   <= 1'b0;
      cpu_nm    <= 1'b0;
      cpu_id    <= '0;
      cpu_amt   <= '0;
      ex_vld    <= 1'b0;
      ex_id     <= '0;
      ex_amt    <= '0;
      cpu_drop  <= 1'b0;
      exch_drop <= 1'b0;
      last_cpu  <= 1'b0;
      op_cpu    <= 1'b0;
      op_nm     <= 1'b0;
      op_id     <= '0;
      op_amt    <= '0;
    end else begin
      if (grant_cpu) cpu_vld <= 1'b0;
      if (grant_ex)  ex_vld  <= 1'b0;
      if (cpu_go) begin
        if (!cpu_vld || grant_cpu) begin
          cpu_vld <= 1'b1;
          cpu_nm  <= cpu_new_max;
          cpu_id  <= cpu_client_id;
          cpu_amt <= cpu_amount;
        end else begin
          cpu_drop <= 1'b1;
        end
      end
      if (exchange_go) begin
        if (!ex_vld || grant_ex) begin
          ex_vld <= 1'b1;
          ex_id  <= exchange_client_id;
          ex_amt <= exchange_amount;
        end else begin
          exch_drop <= 1'b1;
        end
      end
      if ((state == IDLE) && cpu_vld && ex_vld) last_cpu <= grant_cpu;
      if (grant_cpu) begin
        op_cpu <= 1'b1;
        op_nm  <= cpu_nm;
        op_id  <= cpu_id;
        op_amt <= cpu_amt;
      end else if (grant_ex) begin
        op_cpu <= 1'b0;
        op_nm  <= 1'b0;
        op_id  <= ex_id;
        op_amt <= ex_amt;
      end
    end
  end

  // Table access and order accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCLIENT; i++) begin
        max_tab[i] <= '0;
        acc_tab[i] <= '0;
      end
      rd_max             <= '0;
      rd_acc             <= '0;
      accumulated_orders <= '0;
      cancelled_orders   <= '0;
      order_done         <= 1'b0;
      order_accept       <= 1'b0;
    end else begin
      order_done   <= 1'b0;
      order_accept <= 1'b0;
      if (state == RD) begin
        rd_max <= max_tab[op_id];
        rd_acc <= acc_tab[op_id];
      end
      if (state == WR) begin
        if (op_cpu) begin
          if (op_nm) max_tab[op_id] <= op_amt;
          else       acc_tab[op_id] <= '0;
        end else begin
          order_done <= 1'b1;
          if (fits) begin
            acc_tab[op_id] <= sum[AW-1:0];
            order_accept   <= 1'b1;
            if (accumulated_orders != '1) accumulated_orders <= accumulated_orders + 1'b1;
          end else begin
            if (cancelled_orders != '1) cancelled_orders <= cancelled_orders + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_client_limit_arbiter.sv
// Directed bench for client_limit_arbiter: configuration, ordering, arbitration, overflow, drops and reset.
module tb_client_limit_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_go = 1'b0, cpu_new_max = 1'b0;
  logic [4:0]  cpu_client_id = '0;
  logic [31:0] cpu_amount = '0;
  logic        exchange_go = 1'b0;
  logic [4:0]  exchange_client_id = '0;
  logic [31:0] exchange_amount = '0;
  logic [31:0] accumulated_orders, cancelled_orders;
  logic        order_done, order_accept, busy, cpu_drop, exch_drop;

  int total = 0;
  int bad   = 0;

  client_limit_arbiter #(.NCLIENT(32), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_go(cpu_go), .cpu_new_max(cpu_new_max), .cpu_client_id(cpu_client_id), .cpu_amount(cpu_amount),
    .exchange_go(exchange_go), .exchange_client_id(exchange_client_id), .exchange_amount(exchange_amount),
    .accumulated_orders(accumulated_orders), .cancelled_orders(cancelled_orders),
    .order_done(order_done), .order_accept(order_accept), .busy(busy),
    .cpu_drop(cpu_drop), .exch_drop(exch_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic cpu_req(input logic nm, input logic [4:0] id, input logic [31:0] amt);
    cpu_go = 1'b1; cpu_new_max = nm; cpu_client_id = id; cpu_amount = amt;
    tick();
    cpu_go = 1'b0;
    wait_idle();
  endtask

  task automatic wait_done(output logic acc, output int lat);
    lat = 1;
    while (!order_done && lat < 30) begin
      tick();
      lat++;
    end
    if (!order_done) chk("done_timeout", order_done, 1);
    acc = order_accept;
    tick();
    wait_idle();
  endtask

  task automatic ex_req(input logic [4:0] id, input logic [31:0] amt, output logic acc, output int lat);
    exchange_go = 1'b1; exchange_client_id = id; exchange_amount = amt;
    tick();
    exchange_go = 1'b0;
    wait_done(acc, lat);
  endtask

  logic a;
  int   lat;
  int   dones;

  initial begin
    do_reset();
    chk("rst_accum", accumulated_orders, 0);
    chk("rst_cancel", cancelled_orders, 0);
    chk("rst_done", order_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drops", {cpu_drop, exch_drop}, 0);

    // Config then order: max 100, orders 60, 40, 1
    cpu_req(1'b1, 5'd3, 32'd100);
    ex_req(5'd3, 32'd60, a, lat); chk("cfg_ord60", a, 1);
    ex_req(5'd3, 32'd40, a, lat); chk("cfg_ord40", a, 1);
    ex_req(5'd3, 32'd1, a, lat);  chk("cfg_ord1", a, 0);
    chk("cfg_accum", accumulated_orders, 2);
    chk("cfg_cancel", cancelled_orders, 1);

    // Unconfigured client and go-to-done latency
    do_reset();
    ex_req(5'd7, 32'd1, a, lat);
    chk("uncfg_accept", a, 0);
    chk("uncfg_latency", lat, 4);
    chk("uncfg_cancel", cancelled_orders, 1);
    chk("uncfg_accum", accumulated_orders, 0);

    // Simultaneous requests: CPU wins first tie, exchange the second
    do_reset();
    cpu_go = 1'b1; cpu_new_max = 1'b1; cpu_client_id = 5'd5; cpu_amount = 32'd50;
    exchange_go = 1'b1; exchange_client_id = 5'd5; exchange_amount = 32'd50;
    tick();
    cpu_go = 1'b0; exchange_go = 1'b0;
    wait_done(a, lat);
    chk("tie1_accept", a, 1);
    cpu_go = 1'b1; cpu_new_max = 1'b1; cpu_client_id = 5'd6; cpu_amount = 32'd20;
    exchange_go = 1'b1; exchange_client_id = 5'd6; exchange_amount = 32'd20;
    tick();
    cpu_go = 1'b0; exchange_go = 1'b0;
    wait_done(a, lat);
    chk("tie2_accept", a, 0);
    ex_req(5'd6, 32'd20, a, lat); chk("tie2_after", a, 1);
    chk("tie_accum", accumulated_orders, 2);
    chk("tie_cancel", cancelled_orders, 1);

    // Overflow and clear
    do_reset();
    cpu_req(1'b1, 5'd1, 32'hFFFF_FFFF);
    ex_req(5'd1, 32'hFFFF_FFFF, a, lat); chk("ovf_full", a, 1);
    ex_req(5'd1, 32'd1, a, lat);         chk("ovf_carry", a, 0);
    ex_req(5'd1, 32'd0, a, lat);         chk("ovf_zero_amt", a, 1);
    cpu_req(1'b0, 5'd1, 32'd12345);
    ex_req(5'd1, 32'd1, a, lat);         chk("ovf_after_clr", a, 1);

    // Drop: three consecutive exchange pulses from idle
    do_reset();
    dones = 0;
    exchange_client_id = 5'd2; exchange_amount = 32'd1;
    for (int i = 0; i < 3; i++) begin
      exchange_go = 1'b1;
      tick();
      if (order_done) dones++;
    end
    exchange_go = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (order_done) dones++;
    end
    chk("drop_serviced", dones, 2);
    chk("drop_exch", exch_drop, 1);
    chk("drop_cpu_clean", cpu_drop, 0);
    ex_req(5'd2, 32'd1, a, lat);
    chk("drop_sticky", exch_drop, 1);
    cpu_client_id = 5'd9; cpu_new_max = 1'b1; cpu_amount = 32'd1;
    for (int i = 0; i < 3; i++) begin
      cpu_go = 1'b1;
      tick();
    end
    cpu_go = 1'b0;
    wait_idle();
    chk("drop_cpu", cpu_drop, 1);
    do_reset();
    chk("drop_rst_clear", {cpu_drop, exch_drop}, 0);

    // Reset during WR of an order
    cpu_req(1'b1, 5'd4, 32'd10);
    ex_req(5'd4, 32'd5, a, lat);
    chk("mid_pre_accum", accumulated_orders, 1);
    exchange_go = 1'b1; exchange_client_id = 5'd4; exchange_amount = 32'd3;
    tick();
    exchange_go = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_done", order_done, 0);
    chk("mid_accum", accumulated_orders, 0);
    chk("mid_cancel", cancelled_orders, 0);
    chk("mid_busy", busy, 0);
    tick();
    chk("mid_done_late", order_done, 0);
    ex_req(5'd4, 32'd1, a, lat); chk("mid_max_cleared", a, 0);
    cpu_req(1'b1, 5'd4, 32'd10);
    ex_req(5'd4, 32'd10, a, lat); chk("mid_acc_cleared", a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/client_limit_arbiter.md
# client_limit_arbiter

Serialises CPU limit-configuration requests and exchange order requests onto one shared per-client risk table (32 clients × {max, accumulated}). It sits between the CPU/exchange request ports and the order-accounting outputs, in the `clk` domain. Each side has a one-deep pending slot, and the table is granted round-robin. Exchange orders are accepted or cancelled against the client's configured maximum.

## Interface
- `NCLIENT`, 32 — table depth; client id width is fixed at 5.
- `AW`, 32 — amount, max and accumulator width.

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_go`  in  1  one-cycle request pulse from the CPU.
- `cpu_new_max`  in  1  1: set max[id]=amount; 0: clear acc[id] to 0 (amount ignored).
- `cpu_client_id`  in  5  CPU target client.
- `cpu_amount`  in  32  new maximum.
- `exchange_go`  in  1  one-cycle order pulse.
- `exchange_client_id`  in  5  ordering client.
- `exchange_amount`  in  32  order size.
- `accumulated_orders`  out  32  count of accepted exchange orders; saturates at 0xFFFF_FFFF.
- `cancelled_orders`  out  32  count of rejected exchange orders; saturates.
- `order_done`  out  1  one-cycle pulse when an exchange order is resolved.
- `order_accept`  out  1  valid with `order_done`: 1 = accepted, 0 = cancelled.
- `busy`  out  1  FSM not in IDLE, or either pending slot occupied.
- `cpu_drop`  out  1  sticky; a `cpu_go` was lost because its slot was full.
- `exch_drop`  out  1  sticky; an `exchange_go` was lost.

## Operation
- **Pending slots** (CPU, EXCH):
  - Each slot holds valid + request fields.
  - A go pulse loads its slot if the slot is empty or is being granted in the same cycle.
  - Otherwise the request is discarded and the matching drop flag is set.
- **FSM**: IDLE → RD → WR → IDLE.
  - **IDLE**: if any slot is valid, grant one. Copy its fields into the op registers, clear that slot, go to RD.
  - **RD**: issue the table read of max[id] and acc[id]. Data is registered and valid in WR.
  - **WR**: execute the op, write the table and outputs, return to IDLE.
- **Arbitration**:
  - A `last_grant` bit alternates between CPU and EXCH when both slots are valid.
  - If only one slot is valid, it is granted.
  - `last_grant` resets to EXCH, so CPU wins the first tie.
- **CPU op**: `new_max`=1 writes max[id]=amount; 0 writes acc[id]=0. Counters and `order_done` are unchanged.
- **Exchange op**:
  - sum = acc[id] + amount, computed at 33 bits.
  - If sum ≤ max[id] (no carry): acc[id] = sum[31:0], `accumulated_orders`+1, `order_accept`=1.
  - Otherwise: table unchanged, `cancelled_orders`+1, `order_accept`=0.
  - `order_done`=1 in either case.
  - Amount 0 is accepted when acc ≤ max.
- **Reset**:
  - All max[] and acc[] = 0, so every order is cancelled until configured.
  - Counters = 0; `order_done`, `order_accept`, `busy`, `cpu_drop`, `exch_drop` = 0.
  - Slots are empty, FSM = IDLE, `last_grant` = EXCH.
  - Reset mid-transaction aborts it with no table write.
  - Drop flags clear only on reset.

## Timing
- Go pulse in cycle T, slot empty, FSM idle, no competitor:
  - slot valid T+1
  - RD T+2
  - WR T+3
  - `order_done` and the updated counters/table visible in T+4
- Throughput: one transaction per 3 cycles. A slot refilled during its own grant cycle is re-granted 3 cycles later, or 6 if the other side wins.
- Same-client operations are strictly ordered by grant order; no read-after-write hazard exists.
- `order_done`/`order_accept` are registered outputs, high for exactly one cycle.
- Counters saturate: an increment at 0xFFFF_FFFF holds the value.

## Test plan
- **Config then order**: reset; CPU `new_max`=1, id 3, amount 100; exchange id 3, amounts 60 then 40 then 1.
  - Required: accepts, accepts, cancels.
  - `accumulated_orders`=2, `cancelled_orders`=1.
- **Unconfigured client**: exchange id 7, amount 1 after reset → `order_accept`=0, `cancelled_orders`=1, `order_done` exactly 4 cycles after go.
- **Simultaneous go**:
  - Same cycle: CPU (id 5, max 50) and exchange (id 5, amount 50).
  - CPU is granted first, so the order is accepted.
  - Repeat with another tie: exchange is granted first.
- **Overflow and clear**:
  - max[1]=0xFFFF_FFFF, order 0xFFFF_FFFF → accepted.
  - Order 1 → cancelled (carry).
  - CPU `new_max`=0 id 1, then order 1 → accepted.
- **Drop**: three `exchange_go` pulses on consecutive cycles from idle.
  - First two are serviced; third is dropped.
  - `exch_drop`=1 and stays 1 until `rst`.
- **Mid-op reset**: assert `rst` during WR of an order → counters 0, table 0, no `order_done`, `busy`=0 the next cycle.
